ld_driver_mc: RTL and testbench

Multi-channel, parametrised laser-diode current ramp controller. Each channel independently ramps a digital current setpoint up to a programmable ceiling, holds it, and ramps it back to zero at a separate rate under a shared master switch. A global latched fault forces every channel to zero immediately. The block sits between the front-panel/enable logic and the per-channel DAC current drivers.

---
 rtl/ld_driver_mc.sv | 157 +++++++++++++++
 tb/tb_ld_driver_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_driver_mc.sv
`default_nettype none
// ============================================================================
//  Module   : ld_driver_mc
//  Purpose  : Multi-channel laser-diode current ramp controller. Each channel
//             ramps its setpoint up to I_MAX, holds, and ramps back to zero
//             at an independent rate. SW_ON gates every channel. A latched
//             global fault forces all channels to zero on the next edge.
//  Ports    : CLK     - clock
//             Clrn    - asynchronous active-low reset
//             SW_ON   - master enable shared by all channels
//             LD_ON   - per-channel laser-on request [N_CH]
//             FAULT   - global interlock input, level-sensitive
//             I_out   - channel i setpoint on [i*IW +: IW]
//             ST      - channel i state on [2i +: 2] (IDLE/UP/DN/HOLD)
//             AT_MAX  - channel i is in HOLD
//             ACTIVE  - channel i is not IDLE
//             FLT     - fault latch
//  Revision : 1.0 - initial release
// ============================================================================
module ld_driver_mc #(
  parameter int N_CH   = 2,
  parameter int IW     = 12,
  parameter int I_MAX  = 2000,
  parameter int STEP   = 2,
  parameter int UP_DIV = 1000,
  parameter int DN_DIV = 500
) (
  input  logic                 CLK,
  input  logic                 Clrn,
  input  logic                 SW_ON,
  input  logic [N_CH-1:0]      LD_ON,
  input  logic                 FAULT,
  output logic [N_CH*IW-1:0]   I_out,
  output logic [2*N_CH-1:0]    ST,
  output logic [N_CH-1:0]      AT_MAX,
  output logic [N_CH-1:0]      ACTIVE,
  output logic                 FLT
);

  localparam int MAX_DIV = (UP_DIV > DN_DIV) ? UP_DIV : DN_DIV;
  localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CW-1:0] C_UP_LAST = CW'(UP_DIV - 1);
  localparam logic [CW-1:0] C_DN_LAST = CW'(DN_DIV - 1);
  // One extra bit so that I+STEP cannot wrap before the ceiling compare
  localparam logic [IW:0]   C_STEP    = (IW+1)'(STEP);
  localparam logic [IW:0]   C_IMAX    = (IW+1)'(I_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DN   = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  logic [N_CH-1:0] ld_req_q;
  logic            fault_lat_q;

  // Request sampling and fault latch. The latch re-arms only with the
  // master switch off, so a fault cannot silently clear while lasing.
  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      ld_req_q    <= '0;
      fault_lat_q <= 1'b0;
    end else begin
      ld_req_q <= LD_ON;
      if (FAULT)
        fault_lat_q <= 1'b1;
      else if (!SW_ON)
        fault_lat_q <= 1'b0;
    end
  end

  assign FLT = fault_lat_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t          st_q,  st_d;
    logic [IW-1:0]   i_q,   i_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            w_en;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_up_val;
    logic [IW-1:0]   w_dn_val;

    assign w_en     = SW_ON & ld_req_q[g] & ~fault_lat_q;
    assign w_sum    = {1'b0, i_q} + C_STEP;
    assign w_up_val = (w_sum > C_IMAX) ? C_IMAX[IW-1:0] : w_sum[IW-1:0];
    assign w_dn_val = ({1'b0, i_q} > C_STEP) ? (i_q - C_STEP[IW-1:0]) : '0;

    always_comb begin
      st_d  = st_q;
      i_d   = i_q;
      cnt_d = cnt_q;
      if (fault_lat_q) begin
        // Hard zero: bypasses the ramp and overrides every transition
        st_d  = S_IDLE;
        i_d   = '0;
        cnt_d = '0;
      end else begin
        case (st_q)
          S_IDLE: begin
            i_d   = '0;
            cnt_d = '0;
            if (w_en) st_d = S_UP;
          end
          S_UP: begin
            if (!w_en) begin
              st_d  = S_DN;
              cnt_d = '0;
            end else if (cnt_q == C_UP_LAST) begin
              i_d   = w_up_val;
              cnt_d = '0;
              if (w_up_val == C_IMAX[IW-1:0]) st_d = S_HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_HOLD: begin
            cnt_d = '0;
            if (!w_en) st_d = S_DN;
          end
          S_DN: begin
            if (w_en) begin
              st_d  = S_UP;
              cnt_d = '0;
            end else if (cnt_q == C_DN_LAST) begin
              i_d   = w_dn_val;
              cnt_d = '0;
              if (w_dn_val == '0) st_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
    end

    always_ff @(posedge CLK or negedge Clrn) begin
      if (!Clrn) begin
        st_q  <= S_IDLE;
        i_q   <= '0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        i_q   <= i_d;
        cnt_q <= cnt_d;
      end
    end

    assign I_out[g*IW +: IW] = i_q;
    assign ST[2*g +: 2]      = st_q;
    assign AT_MAX[g]         = (st_q == S_HOLD);
    assign ACTIVE[g]         = (st_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_ld_driver_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ld_driver_mc
//  Purpose  : Scoreboard bench for ld_driver_mc (N_CH=2, IW=6, I_MAX=10,
//             STEP=3, UP_DIV=4, DN_DIV=2). Stimulus queues expected output
//             snapshots tagged with the clock edge they belong to; a monitor
//             compares them just after that edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ld_driver_mc;

  localparam int N_CH = 2, IW = 6, I_MAX = 10, STEP = 3, UP_DIV = 4, DN_DIV = 2;
  localparam int ID = 0, UP = 1, DN = 2, HD = 3;

  logic              CLK = 1'b0;
  logic              Clrn;
  logic              SW_ON;
  logic [N_CH-1:0]   LD_ON;
  logic              FAULT;
  logic [N_CH*IW-1:0] I_out;
  logic [2*N_CH-1:0] ST;
  logic [N_CH-1:0]   AT_MAX;
  logic [N_CH-1:0]   ACTIVE;
  logic              FLT;

  ld_driver_mc #(
    .N_CH(N_CH), .IW(IW), .I_MAX(I_MAX), .STEP(STEP),
    .UP_DIV(UP_DIV), .DN_DIV(DN_DIV)
  ) dut (
    .CLK(CLK), .Clrn(Clrn), .SW_ON(SW_ON), .LD_ON(LD_ON), .FAULT(FAULT),
    .I_out(I_out), .ST(ST), .AT_MAX(AT_MAX), .ACTIVE(ACTIVE), .FLT(FLT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          tag;
    logic [11:0] iout;
    logic [3:0]  st;
    logic [1:0]  atm;
    logic [1:0]  act;
    logic        flt;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  // Queue the expected snapshot for the edge d cycles after the current one
  function automatic void exp_at(int d, int i0, int s0, int i1, int s1,
                                 logic flt, string nm);
    exp_t        e;
    logic [5:0]  a0, a1;
    logic [1:0]  b0, b1;
    a0 = 6'(i0);
    a1 = 6'(i1);
    b0 = 2'(s0);
    b1 = 2'(s1);
    e.tag  = cyc + d;
    e.iout = {a1, a0};
    e.st   = {b1, b0};
    e.atm  = {(s1 == HD), (s0 == HD)};
    e.act  = {(s1 != ID), (s0 != ID)};
    e.flt  = flt;
    e.nm   = nm;
    sb.push_back(e);
  endfunction

  task automatic wn(int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: owns the edge counter, checks every snapshot due at this edge
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.tag != cyc || I_out !== e.iout || ST !== e.st ||
            AT_MAX !== e.atm || ACTIVE !== e.act || FLT !== e.flt) begin
          n_bad++;
          $display("FAIL %s edge=%0d due=%0d: got I1=%0d I0=%0d ST=%b AT_MAX=%b ACTIVE=%b FLT=%b, want I1=%0d I0=%0d ST=%b AT_MAX=%b ACTIVE=%b FLT=%b",
                   e.nm, cyc, e.tag, I_out[11:6], I_out[5:0], ST, AT_MAX, ACTIVE, FLT,
                   e.iout[11:6], e.iout[5:0], e.st, e.atm, e.act, e.flt);
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   guard;
    Clrn  = 1'b0;
    SW_ON = 1'b0;
    LD_ON = 2'b00;
    FAULT = 1'b0;

    // Reset state, then idle after release
    wn(1);
    exp_at(1, 0, ID, 0, ID, 1'b0, "rst_hold");
    wn(1);
    Clrn = 1'b1;
    exp_at(1, 0, ID, 0, ID, 1'b0, "rst_rel");
    exp_at(3, 0, ID, 0, ID, 1'b0, "idle_after_rst");
    wn(4);

    // Ramp-up on ch0 with saturation at 10
    SW_ON = 1'b1;
    LD_ON = 2'b01;
    exp_at( 1,  0, ID, 0, ID, 1'b0, "b_req_only");
    exp_at( 2,  0, UP, 0, ID, 1'b0, "b_enter_up");
    exp_at( 5,  0, UP, 0, ID, 1'b0, "b_before_tick");
    exp_at( 6,  3, UP, 0, ID, 1'b0, "b_i3");
    exp_at(10,  6, UP, 0, ID, 1'b0, "b_i6");
    exp_at(14,  9, UP, 0, ID, 1'b0, "b_i9");
    exp_at(17,  9, UP, 0, ID, 1'b0, "b_before_sat");
    exp_at(18, 10, HD, 0, ID, 1'b0, "b_hold10");
    wn(20);

    // Ramp-down from HOLD to zero
    LD_ON = 2'b00;
    exp_at( 1, 10, HD, 0, ID, 1'b0, "c_still_hold");
    exp_at( 2, 10, DN, 0, ID, 1'b0, "c_enter_dn");
    exp_at( 3, 10, DN, 0, ID, 1'b0, "c_before_tick");
    exp_at( 4,  7, DN, 0, ID, 1'b0, "c_i7");
    exp_at( 6,  4, DN, 0, ID, 1'b0, "c_i4");
    exp_at( 8,  1, DN, 0, ID, 1'b0, "c_i1");
    exp_at( 9,  1, DN, 0, ID, 1'b0, "c_before_zero");
    exp_at(10,  0, ID, 0, ID, 1'b0, "c_idle0");
    wn(11);

    // Reversal during UP at 6, then both channels up, then fault pulse
    LD_ON = 2'b01;
    exp_at(10, 6, UP, 0, ID, 1'b0, "d_i6");
    exp_at(11, 6, UP, 0, ID, 1'b0, "d_req_lag");
    exp_at(12, 6, DN, 0, ID, 1'b0, "d_rev_dn");
    exp_at(13, 6, DN, 0, ID, 1'b0, "d_dn_wait");
    exp_at(14, 3, DN, 0, ID, 1'b0, "d_dn_tick3");
    exp_at(15, 3, UP, 0, UP, 1'b0, "d_rev_up");
    exp_at(18, 3, UP, 0, UP, 1'b0, "d_fresh_period");
    exp_at(19, 6, UP, 3, UP, 1'b0, "d_up_tick");
    exp_at(23, 9, UP, 6, UP, 1'b0, "d_pre_fault");
    exp_at(24, 9, UP, 6, UP, 1'b1, "d_flt_latched");
    exp_at(25, 0, ID, 0, ID, 1'b1, "d_hard_zero");
    exp_at(30, 0, ID, 0, ID, 1'b1, "d_flt_sticky");
    wn(10);
    LD_ON = 2'b00;
    wn(3);
    LD_ON = 2'b11;
    wn(10);
    FAULT = 1'b1;
    wn(1);
    FAULT = 1'b0;
    wn(6);

    // Re-arm by switching off, then restart from zero
    SW_ON = 1'b0;
    exp_at( 1,  0, ID,  0, ID, 1'b0, "e_rearm");
    exp_at( 2,  0, UP,  0, UP, 1'b0, "e_restart");
    exp_at( 6,  3, UP,  3, UP, 1'b0, "e_from_zero");
    exp_at(18, 10, HD, 10, HD, 1'b0, "e_both_hold");
    wn(1);
    SW_ON = 1'b1;
    wn(19);

    // Independence: ch0 holds at 10 while ch1 goes DN then UP
    LD_ON = 2'b01;
    exp_at( 1, 10, HD, 10, HD, 1'b0, "f_lag");
    exp_at( 2, 10, HD, 10, DN, 1'b0, "f_ch1_dn");
    exp_at( 4, 10, HD,  7, DN, 1'b0, "f_ch1_i7");
    exp_at( 5, 10, HD,  7, DN, 1'b0, "f_ch1_cnt");
    exp_at( 6, 10, HD,  7, UP, 1'b0, "f_ch1_up");
    exp_at( 9, 10, HD,  7, UP, 1'b0, "f_ch1_wait");
    exp_at(10, 10, HD, 10, HD, 1'b0, "f_ch1_sat");
    wn(4);
    LD_ON = 2'b11;
    wn(16);

    // Asynchronous reset mid-ramp (ch0 at 6)
    LD_ON = 2'b00;
    exp_at( 2, 10, DN, 10, DN, 1'b0, "g_dn");
    exp_at( 4,  7, DN,  7, DN, 1'b0, "g_i7");
    exp_at(10,  0, ID,  0, ID, 1'b0, "g_idle");
    exp_at(13,  0, UP,  0, ID, 1'b0, "g_up");
    exp_at(17,  3, UP,  0, ID, 1'b0, "g_i3");
    exp_at(21,  6, UP,  0, ID, 1'b0, "g_i6");
    exp_at(22,  6, UP,  0, ID, 1'b0, "g_pre_rst");
    exp_at(23,  0, ID,  0, ID, 1'b0, "g_async_rst");
    exp_at(24,  0, UP,  0, ID, 1'b0, "g_resample");
    wn(11);
    LD_ON = 2'b01;
    wn(11);
    Clrn = 1'b0;
    #1;
    n_cmp++;
    if (I_out !== '0) begin
      n_bad++;
      $display("FAIL g_async_iout: got I_out=%h, want 0", I_out);
    end
    n_cmp++;
    if (ST !== '0) begin
      n_bad++;
      $display("FAIL g_async_st: got ST=%b, want 0", ST);
    end
    n_cmp++;
    if (AT_MAX !== '0) begin
      n_bad++;
      $display("FAIL g_async_atmax: got AT_MAX=%b, want 0", AT_MAX);
    end
    n_cmp++;
    if (ACTIVE !== '0) begin
      n_bad++;
      $display("FAIL g_async_active: got ACTIVE=%b, want 0", ACTIVE);
    end
    n_cmp++;
    if (FLT !== 1'b0) begin
      n_bad++;
      $display("FAIL g_async_flt: got FLT=%b, want 0", FLT);
    end
    #1;
    Clrn = 1'b1;
    wn(4);

    // Drain; anything left unchecked counts as a failure
    guard = 0;
    while (sb.size() > 0 && guard < 30) begin
      wn(1);
      guard++;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no check by edge %0d, want check at edge %0d", e.nm, cyc, e.tag);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
